// File: rtl/fixed_clamp_pkg.sv
// fixed_clamp_pkg
// Shared types and width helpers for the fixed_clamp_pipe activation.
// Contents:
//   clamp_mode_e  - runtime clamp mode (HARDTANH, RELU, RELU6, BYPASS)
//   shift_dist    - distance between input and output fractional bit counts
//   mid_width     - width of the intermediate that holds a converted value
//                   without overflow (input width + shift distance + 1)
package fixed_clamp_pkg;

  typedef enum logic [1:0] {
    MODE_HARDTANH = 2'd0,
    MODE_RELU     = 2'd1,
    MODE_RELU6    = 2'd2,
    MODE_BYPASS   = 2'd3
  } clamp_mode_e;

  function automatic int shift_dist(input int frac_in, input int frac_out);
    return (frac_out >= frac_in) ? (frac_out - frac_in) : (frac_in - frac_out);
  endfunction

  function automatic int mid_width(input int width_in, input int frac_in, input int frac_out);
    return width_in + shift_dist(frac_in, frac_out) + 1;
  endfunction

endpackage

// File: rtl/fixed_clamp_lane.sv
// fixed_clamp_lane
// Combinational clamp, fixed-point precision conversion (round half up) and
// output saturation for a single lane.
// Ports:
//   mode  in   clamp mode
//   lo    in   signed lower bound (input format, HARDTANH only)
//   hi    in   signed upper bound (input format, HARDTANH only)
//   din   in   signed input value
//   dout  out  signed converted value
//   sat   out  lane was clamped by a bound or saturated on output
module fixed_clamp_lane import fixed_clamp_pkg::*; #(
  parameter int IN_W  = 8,
  parameter int IN_F  = 4,
  parameter int OUT_W = 8,
  parameter int OUT_F = 4
) (
  input  clamp_mode_e              mode,
  input  logic signed [IN_W-1:0]   lo,
  input  logic signed [IN_W-1:0]   hi,
  input  logic signed [IN_W-1:0]   din,
  output logic signed [OUT_W-1:0]  dout,
  output logic                     sat
);

  localparam int D     = shift_dist(IN_F, OUT_F);
  localparam int MID_W = mid_width(IN_W, IN_F, OUT_F);
  localparam int CMP_W = (MID_W > OUT_W) ? MID_W : OUT_W;

  // 6.0 in the input format, pulled down to the input maximum when it does
  // not fit.
  localparam longint SIX    = longint'(6) << IN_F;
  localparam longint IN_MAX = (longint'(1) << (IN_W - 1)) - 1;
  localparam logic signed [IN_W-1:0] RELU6_HI = (SIX > IN_MAX) ? IN_W'(IN_MAX) : IN_W'(SIX);

  localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  logic signed [IN_W-1:0]  clip;
  logic                    clamped;
  logic signed [MID_W-1:0] ext;
  logic signed [MID_W-1:0] wide;
  logic signed [CMP_W-1:0] wext;
  logic                    out_sat;

  always_comb begin
    clip    = din;
    clamped = 1'b0;
    case (mode)
      MODE_HARDTANH: begin
        // Upper check last so an inverted range (lo > hi) always yields hi.
        if (clip < lo) begin
          clip    = lo;
          clamped = 1'b1;
        end
        if (clip > hi) begin
          clip    = hi;
          clamped = 1'b1;
        end
      end
      MODE_RELU: begin
        if (din[IN_W-1]) begin
          clip    = '0;
          clamped = 1'b1;
        end
      end
      MODE_RELU6: begin
        if (din[IN_W-1]) begin
          clip    = '0;
          clamped = 1'b1;
        end else if (din > RELU6_HI) begin
          clip    = RELU6_HI;
          clamped = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign ext = MID_W'(clip);

  generate
    if (OUT_F >= IN_F) begin : g_up
      assign wide = ext <<< D;
    end else begin : g_down
      localparam logic signed [MID_W-1:0] RND = MID_W'(1) << (D - 1);
      assign wide = (ext + RND) >>> D;
    end
  endgenerate

  assign wext = CMP_W'(wide);

  always_comb begin
    dout    = wext[OUT_W-1:0];
    out_sat = 1'b0;
    if (wext > CMP_W'(OUT_MAX)) begin
      dout    = OUT_MAX;
      out_sat = 1'b1;
    end else if (wext < CMP_W'(OUT_MIN)) begin
      dout    = OUT_MIN;
      out_sat = 1'b1;
    end
  end

  assign sat = clamped | out_sat;

endmodule

// File: rtl/fixed_clamp_pipe.sv
// fixed_clamp_pipe
// Pipelined multi-mode clamp activation on a valid/ready stream: N lanes of
// clamp + precision conversion, an output register backed by one skid
// register, runtime configuration registers and a sticky saturation counter.
// Ports:
//   clk, rst                   clock, asynchronous active-low reset
//   cfg_valid                  load cfg_mode/cfg_min/cfg_max at this edge
//   cfg_mode                   0 HARDTANH, 1 RELU, 2 RELU6, 3 BYPASS
//   cfg_min, cfg_max           signed HARDTANH bounds (input format)
//   cfg_clear                  synchronous clear of sat_count
//   data_in_0[_valid/_ready]   input stream, N lanes
//   data_out_0[_valid/_ready]  output stream, N lanes
//   sat_count                  lanes clamped/saturated since clear, sticky at max
module fixed_clamp_pipe import fixed_clamp_pkg::*; #(
  parameter int DATA_IN_0_PRECISION_0        = 8,
  parameter int DATA_IN_0_PRECISION_1        = 4,
  parameter int DATA_IN_0_TENSOR_SIZE_DIM_0  = 8,
  parameter int DATA_IN_0_TENSOR_SIZE_DIM_1  = 1,
  parameter int DATA_IN_0_PARALLELISM_DIM_0  = 1,
  parameter int DATA_IN_0_PARALLELISM_DIM_1  = 1,
  parameter int DATA_OUT_0_PRECISION_0       = 8,
  parameter int DATA_OUT_0_PRECISION_1       = 4,
  parameter int DATA_OUT_0_TENSOR_SIZE_DIM_0 = 8,
  parameter int DATA_OUT_0_TENSOR_SIZE_DIM_1 = 1,
  parameter int DATA_OUT_0_PARALLELISM_DIM_0 = 1,
  parameter int DATA_OUT_0_PARALLELISM_DIM_1 = 1,
  parameter int DEFAULT_MIN                  = -16,
  parameter int DEFAULT_MAX                  = 16,
  parameter int CNT_WIDTH                    = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                cfg_valid,
  input  logic [1:0]                          cfg_mode,
  input  logic [DATA_IN_0_PRECISION_0-1:0]    cfg_min,
  input  logic [DATA_IN_0_PRECISION_0-1:0]    cfg_max,
  input  logic                                cfg_clear,
  input  logic [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1-1:0][DATA_IN_0_PRECISION_0-1:0] data_in_0,
  input  logic                                data_in_0_valid,
  output logic                                data_in_0_ready,
  output logic [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1-1:0][DATA_OUT_0_PRECISION_0-1:0] data_out_0,
  output logic                                data_out_0_valid,
  input  logic                                data_out_0_ready,
  output logic [CNT_WIDTH-1:0]                sat_count
);

  localparam int N     = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1;
  localparam int IN_W  = DATA_IN_0_PRECISION_0;
  localparam int OUT_W = DATA_OUT_0_PRECISION_0;
  localparam int PW    = $clog2(N + 1);
  localparam int SUM_W = ((CNT_WIDTH > PW) ? CNT_WIDTH : PW) + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_WIDTH{1'b1}});

  generate
    if (DATA_OUT_0_TENSOR_SIZE_DIM_0 != DATA_IN_0_TENSOR_SIZE_DIM_0 ||
        DATA_OUT_0_TENSOR_SIZE_DIM_1 != DATA_IN_0_TENSOR_SIZE_DIM_1 ||
        DATA_OUT_0_PARALLELISM_DIM_0 != DATA_IN_0_PARALLELISM_DIM_0 ||
        DATA_OUT_0_PARALLELISM_DIM_1 != DATA_IN_0_PARALLELISM_DIM_1) begin : g_shape_err
      $error("fixed_clamp_pipe: output tensor shape must equal input tensor shape");
    end
  endgenerate

  clamp_mode_e             mode_q;
  logic signed [IN_W-1:0]  min_q;
  logic signed [IN_W-1:0]  max_q;

  logic [N-1:0][OUT_W-1:0] lane_out;
  logic [N-1:0]            lane_sat;
  logic [N-1:0][OUT_W-1:0] skid_data;
  logic                    skid_valid;
  logic                    accept;
  logic                    out_free;
  logic [PW-1:0]           pop;
  logic [SUM_W-1:0]        sum;
  logic [CNT_WIDTH-1:0]    cnt_next;

  generate
    for (genvar g = 0; g < N; g++) begin : g_lane
      fixed_clamp_lane #(
        .IN_W  (IN_W),
        .IN_F  (DATA_IN_0_PRECISION_1),
        .OUT_W (OUT_W),
        .OUT_F (DATA_OUT_0_PRECISION_1)
      ) u_lane (
        .mode (mode_q),
        .lo   (min_q),
        .hi   (max_q),
        .din  (data_in_0[g]),
        .dout (lane_out[g]),
        .sat  (lane_sat[g])
      );
    end
  endgenerate

  // Ready comes straight from the skid flag, so nothing downstream reaches
  // upstream combinationally.
  assign data_in_0_ready = ~skid_valid;
  assign accept          = data_in_0_valid & data_in_0_ready;
  assign out_free        = ~data_out_0_valid | data_out_0_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q <= MODE_HARDTANH;
      min_q  <= IN_W'(DEFAULT_MIN);
      max_q  <= IN_W'(DEFAULT_MAX);
    end else if (cfg_valid) begin
      mode_q <= clamp_mode_e'(cfg_mode);
      min_q  <= cfg_min;
      max_q  <= cfg_max;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out_0       <= '0;
      data_out_0_valid <= 1'b0;
      skid_data        <= '0;
      skid_valid       <= 1'b0;
    end else if (out_free) begin
      // Skid always drains first; ready is low while it is full, so no new
      // beat can arrive in the same cycle.
      if (skid_valid) begin
        data_out_0       <= skid_data;
        data_out_0_valid <= 1'b1;
        skid_valid       <= 1'b0;
      end else if (accept) begin
        data_out_0       <= lane_out;
        data_out_0_valid <= 1'b1;
      end else begin
        data_out_0_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_data  <= lane_out;
      skid_valid <= 1'b1;
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < N; i++) begin
      pop = pop + PW'(lane_sat[i]);
    end
  end

  assign sum      = SUM_W'(sat_count) + SUM_W'(pop);
  assign cnt_next = (sum > CNT_MAX) ? {CNT_WIDTH{1'b1}} : sum[CNT_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat_count <= '0;
    end else if (cfg_clear) begin
      sat_count <= '0;
    end else if (accept) begin
      sat_count <= cnt_next;
    end
  end

endmodule

// File: tb/tb_fixed_clamp_pipe.sv
// tb_fixed_clamp_pipe
// Directed bench for fixed_clamp_pipe. Three instances share one stimulus:
//   u_main  default formats, 2 lanes, 16-bit counter
//   u_prec  output fractional bits = 2 (rounding checks)
//   u_cnt   2-bit counter (sticky saturation checks)
module tb_fixed_clamp_pipe;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            cfg_valid = 1'b0;
  logic [1:0]      cfg_mode = 2'd0;
  logic [7:0]      cfg_min = 8'hF0;
  logic [7:0]      cfg_max = 8'h10;
  logic            cfg_clear = 1'b0;
  logic [1:0][7:0] din = '0;
  logic            din_valid = 1'b0;
  logic            dout_ready = 1'b1;

  logic [1:0][7:0] main_out, prec_out, cnt_out;
  logic            main_valid, prec_valid, cnt_valid;
  logic            main_rdy, prec_rdy, cnt_rdy;
  logic [15:0]     main_sat, prec_sat;
  logic [1:0]      cnt_sat;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] rcv [0:7];
  logic        ready_log [0:31];
  int          nrcv;
  int          idx;

  always #5 clk = ~clk;

  fixed_clamp_pipe #(
    .DATA_IN_0_PARALLELISM_DIM_0 (2),
    .DATA_OUT_0_PARALLELISM_DIM_0(2)
  ) u_main (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_mode(cfg_mode),
    .cfg_min(cfg_min), .cfg_max(cfg_max), .cfg_clear(cfg_clear),
    .data_in_0(din), .data_in_0_valid(din_valid), .data_in_0_ready(main_rdy),
    .data_out_0(main_out), .data_out_0_valid(main_valid), .data_out_0_ready(dout_ready),
    .sat_count(main_sat)
  );

  fixed_clamp_pipe #(
    .DATA_IN_0_PARALLELISM_DIM_0 (2),
    .DATA_OUT_0_PARALLELISM_DIM_0(2),
    .DATA_OUT_0_PRECISION_1      (2)
  ) u_prec (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_mode(cfg_mode),
    .cfg_min(cfg_min), .cfg_max(cfg_max), .cfg_clear(cfg_clear),
    .data_in_0(din), .data_in_0_valid(din_valid), .data_in_0_ready(prec_rdy),
    .data_out_0(prec_out), .data_out_0_valid(prec_valid), .data_out_0_ready(dout_ready),
    .sat_count(prec_sat)
  );

  fixed_clamp_pipe #(
    .DATA_IN_0_PARALLELISM_DIM_0 (2),
    .DATA_OUT_0_PARALLELISM_DIM_0(2),
    .CNT_WIDTH                   (2)
  ) u_cnt (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_mode(cfg_mode),
    .cfg_min(cfg_min), .cfg_max(cfg_max), .cfg_clear(cfg_clear),
    .data_in_0(din), .data_in_0_valid(din_valid), .data_in_0_ready(cnt_rdy),
    .data_out_0(cnt_out), .data_out_0_valid(cnt_valid), .data_out_0_ready(dout_ready),
    .sat_count(cnt_sat)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] l0, input logic [7:0] l1);
    din[0]    = l0;
    din[1]    = l1;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
  endtask

  task automatic check_main(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                            input logic [15:0] esat);
    check($sformatf("%s_l0", tag), main_out[0], e0);
    check($sformatf("%s_l1", tag), main_out[1], e1);
    check($sformatf("%s_vld", tag), main_valid, 1);
    check($sformatf("%s_sat", tag), main_sat, esat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset
    repeat (3) tick();
    check("rst_vld", main_valid, 0);
    check("rst_rdy", main_rdy, 1);
    check("rst_sat", main_sat, 0);
    check("rst_out", main_out, 0);
    rst = 1'b1;
    tick();

    // HARDTANH with default bounds
    beat(8'h7F, 8'h80);
    check_main("ht_sat", 8'h10, 8'hF0, 16'd2);
    check("ht_cnt", cnt_sat, 2);
    beat(8'h05, 8'hFD);
    check_main("ht_pass", 8'h05, 8'hFD, 16'd2);

    // switch to RELU6; the beat in the config cycle still sees HARDTANH
    cfg_valid = 1'b1;
    cfg_mode  = 2'd2;
    beat(8'h70, 8'hF0);
    cfg_valid = 1'b0;
    check_main("cfg_old", 8'h10, 8'hF0, 16'd3);
    check("cnt_3", cnt_sat, 3);
    beat(8'h70, 8'hF0);
    check_main("relu6", 8'h60, 8'h00, 16'd5);
    check("cnt_stick1", cnt_sat, 3);
    beat(8'h70, 8'h70);
    check_main("relu6_hi", 8'h60, 8'h60, 16'd7);
    check("cnt_stick2", cnt_sat, 3);

    // clear wins over a concurrent saturating beat
    cfg_clear = 1'b1;
    beat(8'h70, 8'h70);
    cfg_clear = 1'b0;
    check("clr_main", main_sat, 0);
    check("clr_cnt", cnt_sat, 0);
    beat(8'h70, 8'h05);
    check_main("after_clr", 8'h60, 8'h05, 16'd1);
    check("after_clr_cnt", cnt_sat, 1);
    check("prec_relu6", prec_out, 16'h0118);

    // BYPASS with precision conversion 4 -> 2 fractional bits
    cfg_valid = 1'b1;
    cfg_mode  = 2'd3;
    tick();
    cfg_valid = 1'b0;
    beat(8'h06, 8'h7F);
    check_main("byp", 8'h06, 8'h7F, 16'd1);
    check("prec_rnd_l0", prec_out[0], 8'h02);
    check("prec_rnd_l1", prec_out[1], 8'h20);
    check("prec_sat", prec_sat, 1);
    beat(8'hFA, 8'h80);
    check("prec_neg_l0", prec_out[0], 8'hFF);
    check("prec_neg_l1", prec_out[1], 8'hE0);
    tick();
    check("drain_vld", main_valid, 0);

    // backpressure: 6 beats, downstream stalls for 3 cycles
    idx  = 0;
    nrcv = 0;
    for (int t = 0; t < 32 && nrcv < 6; t++) begin
      dout_ready   = !(t >= 2 && t <= 4);
      din_valid    = (idx < 6);
      din[0]       = 8'h10 + 8'(idx);
      din[1]       = 8'h20 + 8'(idx);
      ready_log[t] = main_rdy;
      if (t == 4) begin
        check("bp_hold", main_out, 16'h2111);
        check("bp_hold_vld", main_valid, 1);
      end
      if (din_valid && main_rdy) idx++;
      if (main_valid && dout_ready && nrcv < 8) begin
        rcv[nrcv] = main_out;
        nrcv++;
      end
      tick();
    end
    din_valid  = 1'b0;
    dout_ready = 1'b1;
    check("bp_rdy2", ready_log[2], 1);
    check("bp_rdy3", ready_log[3], 0);
    check("bp_rdy5", ready_log[5], 0);
    check("bp_rdy6", ready_log[6], 1);
    check("bp_count", nrcv, 6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("bp_beat%0d", i), rcv[i], {8'h20 + 8'(i), 8'h10 + 8'(i)});
    end
    tick();

    // inverted HARDTANH range collapses to the upper bound
    cfg_valid = 1'b1;
    cfg_mode  = 2'd0;
    cfg_min   = 8'h0A;
    cfg_max   = 8'h03;
    tick();
    cfg_valid = 1'b0;
    beat(8'h7F, 8'h80);
    check_main("inv_rng", 8'h03, 8'h03, 16'd3);

    // RELU
    cfg_valid = 1'b1;
    cfg_mode  = 2'd1;
    tick();
    cfg_valid = 1'b0;
    beat(8'h7F, 8'h81);
    check_main("relu", 8'h7F, 8'h00, 16'd4);

    // reset asserted mid-stream
    din[0]    = 8'h81;
    din[1]    = 8'h81;
    din_valid = 1'b1;
    tick();
    check_main("pre_rst", 8'h00, 8'h00, 16'd6);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_vld", main_valid, 0);
    check("mid_rst_sat", main_sat, 0);
    check("mid_rst_rdy", main_rdy, 1);
    check("mid_rst_out", main_out, 0);
    din_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    beat(8'h7F, 8'h00);
    check_main("post_rst", 8'h10, 8'h00, 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fixed_clamp_pipe.md
# fixed_clamp_pipe

Pipelined, multi-mode fixed-point clamp activation for MASE streaming dataflows; parametrised successor to the combinational hardtanh. Adds runtime-programmable bounds, RELU/RELU6 modes, input-to-output fixed-point precision conversion with rounding and saturation, a registered skid-buffered handshake and a saturation event counter. Sits between compute layers (linear/conv) and downstream stages on the standard `data_*_0` valid/ready stream.

## Interface
Parameters:
- DATA_IN_0_PRECISION_0, 8, input word width (signed)
- DATA_IN_0_PRECISION_1, 4, input fractional bits
- DATA_IN_0_TENSOR_SIZE_DIM_0/1, 8/1, tensor size (informational)
- DATA_IN_0_PARALLELISM_DIM_0/1, 1/1, lanes per beat; N = product
- DATA_OUT_0_PRECISION_0, 8, output word width (signed)
- DATA_OUT_0_PRECISION_1, 4, output fractional bits
- DATA_OUT_0_TENSOR_SIZE_DIM_0/1, PARALLELISM_DIM_0/1, must equal input values
- DEFAULT_MIN, -16, reset lower bound (input format)
- DEFAULT_MAX, 16, reset upper bound (input format)
- CNT_WIDTH, 16, saturation counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- cfg_valid  in  1  load cfg_mode/cfg_min/cfg_max this cycle
- cfg_mode  in  2  0 HARDTANH, 1 RELU, 2 RELU6, 3 BYPASS
- cfg_min, cfg_max  in  DATA_IN_0_PRECISION_0 each  signed bounds, HARDTANH only
- cfg_clear  in  1  synchronous clear of sat_count
- data_in_0  in  N x DATA_IN_0_PRECISION_0  input lanes
- data_in_0_valid  in  1;  data_in_0_ready  out  1
- data_out_0  out  N x DATA_OUT_0_PRECISION_0  output lanes
- data_out_0_valid  out  1;  data_out_0_ready  in  1
- sat_count  out  CNT_WIDTH  lanes clamped or saturated since clear

## Operation
- Per lane, input domain: HARDTANH clamps to [min,max]; RELU clamps below at 0, no upper; RELU6 clamps to [0, 6<<F_i], upper bound saturated to input max if unrepresentable; BYPASS passes through.
- Conversion, F_i = DATA_IN_0_PRECISION_1, F_o = DATA_OUT_0_PRECISION_1: F_o >= F_i shift left by F_o-F_i; F_o < F_i add 2^(F_i-F_o-1) then arithmetic shift right (round half up). Intermediate width = in width + |F_o-F_i| + 1, no overflow. Result saturated to signed DATA_OUT_0_PRECISION_0.
- Lane "saturated" if clamped by bound or by output saturation; sat_count += popcount of saturated lanes per accepted beat; counter sticks at all-ones, never wraps. cfg_clear wins over same-cycle increment (result 0).
- Config: on cfg_valid, mode/min/max registers update at the edge; beats accepted on later cycles use new values, beat accepted in the same cycle uses old. cfg_min > cfg_max is legal: result equals cfg_max for all lanes (upper check applied last).
- Reset values: mode 0, min DEFAULT_MIN, max DEFAULT_MAX, sat_count 0, data_out_0_valid 0, data_out_0 0, data_in_0_ready 1.

## Timing
- Latency 1 cycle: beat accepted at edge k is on data_out_0 after edge k with valid high.
- Throughput 1 beat/cycle with data_out_0_ready held high.
- Output register + one skid register. data_in_0_ready is registered: low only while skid holds a beat. Downstream stall: one further beat absorbed in skid, then ready drops the next cycle.
- When output register drains and skid full, skid moves to output same edge; ready returns high the following cycle.
- data_out_0 and valid stable while valid && !ready; no combinational path valid/ready in to out.
- Reset assertion mid-stream discards both registers immediately; in-flight beats lost, counter zeroed.

## Structure
- Package fixed_clamp_pkg: mode enum (HARDTANH, RELU, RELU6, BYPASS), width helper functions for intermediate width.
- Sub-module fixed_clamp_lane: combinational clamp + round + saturate for one lane, outputs value and saturated flag; generated N times.
- Skid/output registering and counter in the top level.

## Test plan
Defaults (8-bit, 4 frac), N=2 unless stated.
- Reset: hold rst low 3 cycles -> data_out_0_valid 0, data_in_0_ready 1, sat_count 0.
- HARDTANH default: lanes {0x7F, 0x80} -> {16, -16} one cycle later; sat_count = 2; lanes {5, -3} -> {5, -3}, sat_count unchanged.
- RELU6 via cfg: lanes {0x70 (7.0), 0xF0 (-1.0)} -> {96, 0}; sat_count += 2; beat in cfg cycle uses old mode.
- Precision: DATA_OUT_0_PRECISION_1 = 2, BYPASS, input 0x06 (0.375) -> 2 (0.5, rounded up); input 0x7F -> 0x20 (8.0 representable? 127+2>>2=32), no saturation.
- Backpressure: stream 6 beats with data_out_0_ready low for 3 cycles mid-stream -> ready falls one cycle after skid fills, no loss, no duplication, order preserved.
- Counter: CNT_WIDTH=2, 4 saturating beats -> sat_count sticks at 3; cfg_clear with concurrent saturating beat -> 0.
